// File: rtl/regfile_pkg.sv
// Shared core definitions: basic word/address types and the constants used
// by the register file and its forwarding selector.
package regfile_pkg;

   localparam int REG_NUM    = 32;
   localparam int REG_ADDR_W = $clog2(REG_NUM);

   typedef logic                  Bit_t;
   typedef logic [REG_ADDR_W-1:0] Reg_addr_t;
   typedef logic [31:0]           Word_t;

   localparam Bit_t      ENABLE    = 1'b1;
   localparam Bit_t      DISABLE   = 1'b0;
   localparam Reg_addr_t REG_ZERO  = '0;
   localparam Word_t     ZERO_WORD = '0;

endpackage

// File: rtl/regfile_if.sv
// Register-file bus: writeback triple, EX/MEM forwarding sources, the two
// ID read ports, stall request and the write counter.
interface regfile_if;
   import regfile_pkg::*;

   Bit_t      wb_write_i;
   Reg_addr_t wb_addr_i;
   Word_t     wb_data_i;

   Bit_t      ex_write_i;
   Reg_addr_t ex_addr_i;
   Word_t     ex_data_i;
   Bit_t      ex_is_load_i;

   Bit_t      mem_write_i;
   Reg_addr_t mem_addr_i;
   Word_t     mem_data_i;

   Bit_t      re1_i;
   Reg_addr_t raddr1_i;
   Word_t     rdata1_o;
   Bit_t      re2_i;
   Reg_addr_t raddr2_i;
   Word_t     rdata2_o;

   Bit_t      stall_req_o;
   Word_t     wr_count_o;

   // Pipeline side: drives writes/forwarding sources and read requests.
   modport master (
      output wb_write_i, wb_addr_i, wb_data_i,
      output ex_write_i, ex_addr_i, ex_data_i, ex_is_load_i,
      output mem_write_i, mem_addr_i, mem_data_i,
      output re1_i, raddr1_i, re2_i, raddr2_i,
      input  rdata1_o, rdata2_o, stall_req_o, wr_count_o
   );

   // Register-file side.
   modport slave (
      input  wb_write_i, wb_addr_i, wb_data_i,
      input  ex_write_i, ex_addr_i, ex_data_i, ex_is_load_i,
      input  mem_write_i, mem_addr_i, mem_data_i,
      input  re1_i, raddr1_i, re2_i, raddr2_i,
      output rdata1_o, rdata2_o, stall_req_o, wr_count_o
   );

endinterface

// File: rtl/regfile_fwd_mux.sv
// Per-read-port operand selector: youngest in-flight producer wins
// (EX, then MEM, then the same-cycle WB write), else the stored value.
module regfile_fwd_mux
   import regfile_pkg::*;
(
   input  Bit_t      rst_i,
   input  Bit_t      re_i,
   input  Reg_addr_t raddr_i,
   input  Bit_t      ex_write_i,
   input  Reg_addr_t ex_addr_i,
   input  Word_t     ex_data_i,
   input  Bit_t      mem_write_i,
   input  Reg_addr_t mem_addr_i,
   input  Word_t     mem_data_i,
   input  Bit_t      wb_write_i,
   input  Reg_addr_t wb_addr_i,
   input  Word_t     wb_data_i,
   input  Word_t     arr_data_i,
   output Word_t     rdata_o
);

   // Priority chain; r0 is caught first so no stage can ever forward into it.
   always_comb begin
      rdata_o = arr_data_i;
      if (rst_i || (re_i == DISABLE) || (raddr_i == REG_ZERO)) begin
         rdata_o = ZERO_WORD;
      end else if (ex_write_i && (ex_addr_i == raddr_i)) begin
         rdata_o = ex_data_i;
      end else if (mem_write_i && (mem_addr_i == raddr_i)) begin
         rdata_o = mem_data_i;
      end else if (wb_write_i && (wb_addr_i == raddr_i)) begin
         rdata_o = wb_data_i;
      end
   end

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit MIPS register file with internal EX/MEM/WB forwarding,
// load-use stall detection and a committed-write counter.
module regfile
   import regfile_pkg::*;
#(
   parameter int REG_NUM      = regfile_pkg::REG_NUM,
   parameter bit RESET_CLEARS = 1'b1
) (
   input  logic      clk,
   input  logic      rst,
   regfile_if.slave  bus
);

   Word_t regs_q [REG_NUM];
   Word_t wr_count_q;
   Word_t wr_count_d;
   Bit_t  wr_en;
   Bit_t  stall;

   // A write commits only outside reset and never to r0.
   assign wr_en = !rst && bus.wb_write_i && (bus.wb_addr_i != REG_ZERO);

   // Counter next state: wraps naturally at 2^32.
   always_comb begin
      wr_count_d = wr_count_q;
      if (wr_en) begin
         wr_count_d = wr_count_q + 32'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_count_q <= ZERO_WORD;
      end else begin
         wr_count_q <= wr_count_d;
      end
   end

   // Register array; reset clearing is optional since reads are forced to 0 during reset anyway.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (RESET_CLEARS) begin
            for (int i = 0; i < REG_NUM; i++) begin
               regs_q[i] <= ZERO_WORD;
            end
         end
      end else if (wr_en) begin
         regs_q[bus.wb_addr_i] <= bus.wb_data_i;
      end
   end

   // Load in EX whose result an enabled read port needs this cycle.
   always_comb begin
      stall = DISABLE;
      if (!rst && bus.ex_write_i && bus.ex_is_load_i && (bus.ex_addr_i != REG_ZERO)) begin
         stall = (bus.re1_i && (bus.raddr1_i == bus.ex_addr_i)) ||
                 (bus.re2_i && (bus.raddr2_i == bus.ex_addr_i));
      end
   end

   assign bus.stall_req_o = stall;
   assign bus.wr_count_o  = wr_count_q;

   regfile_fwd_mux u_fwd1 (
      .rst_i       (rst),
      .re_i        (bus.re1_i),
      .raddr_i     (bus.raddr1_i),
      .ex_write_i  (bus.ex_write_i),
      .ex_addr_i   (bus.ex_addr_i),
      .ex_data_i   (bus.ex_data_i),
      .mem_write_i (bus.mem_write_i),
      .mem_addr_i  (bus.mem_addr_i),
      .mem_data_i  (bus.mem_data_i),
      .wb_write_i  (bus.wb_write_i),
      .wb_addr_i   (bus.wb_addr_i),
      .wb_data_i   (bus.wb_data_i),
      .arr_data_i  (regs_q[bus.raddr1_i]),
      .rdata_o     (bus.rdata1_o)
   );

   regfile_fwd_mux u_fwd2 (
      .rst_i       (rst),
      .re_i        (bus.re2_i),
      .raddr_i     (bus.raddr2_i),
      .ex_write_i  (bus.ex_write_i),
      .ex_addr_i   (bus.ex_addr_i),
      .ex_data_i   (bus.ex_data_i),
      .mem_write_i (bus.mem_write_i),
      .mem_addr_i  (bus.mem_addr_i),
      .mem_data_i  (bus.mem_data_i),
      .wb_write_i  (bus.wb_write_i),
      .wb_addr_i   (bus.wb_addr_i),
      .wb_data_i   (bus.wb_data_i),
      .arr_data_i  (regs_q[bus.raddr2_i]),
      .rdata_o     (bus.rdata2_o)
   );

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- General-purpose register file for the 5-stage MIPS core, with 32 x 32-bit registers.
- Receives the writeback triple (wreg_write, wreg_addr, wreg_data) that the MEM stage forwards through MEM/WB. Sits beside ID, which reads operands from it.
- Resolves operand hazards internally: forwards from EX, MEM and the same-cycle WB write, and raises a load-use stall request.

Parameters:
- REG_NUM, 32, number of architectural registers (address width $clog2(REG_NUM) = 5).
- RESET_CLEARS, 1, when 1, synchronous reset zeroes every register; when 0, only the outputs are forced.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  reset: synchronous, active-high.
- wb_write_i  input  1  writeback enable from MEM/WB.
- wb_addr_i  input  5  writeback destination.
- wb_data_i  input  32  writeback data.
- ex_write_i  input  1  EX-stage result will write a register.
- ex_addr_i  input  5  EX-stage destination.
- ex_data_i  input  32  EX-stage ALU result.
- ex_is_load_i  input  1  EX-stage instruction is a load (data not yet available).
- mem_write_i  input  1  MEM-stage result will write a register.
- mem_addr_i  input  5  MEM-stage destination.
- mem_data_i  input  32  MEM-stage result (load data included).
- re1_i  input  1  read port 1 enable.
- raddr1_i  input  5  read port 1 address.
- rdata1_o  output  32  read port 1 data.
- re2_i  input  1  read port 2 enable.
- raddr2_i  input  5  read port 2 address.
- rdata2_o  output  32  read port 2 data.
- stall_req_o  output  1  load-use stall request to pipeline control.
- wr_count_o  output  32  count of committed architectural writes (debug/perf).

Behaviour:
- Write, sequential: on a rising edge with rst=0, if wb_write_i=1 and wb_addr_i!=0, then regs[wb_addr_i] <= wb_data_i and wr_count_o increments by 1, wrapping 0xFFFFFFFF -> 0.
- Writes to r0 are discarded and not counted.
- Reset: on a rising edge with rst=1, wr_count_o <= 0. If RESET_CLEARS=1, all regs <= 0.
- While rst=1, regardless of the other inputs:
  - rdata1_o = rdata2_o = 0.
  - stall_req_o = 0.
  - no write occurs.
  - Reset mid-operation aborts any write presented in that cycle.
- Read, combinational, zero latency. For each port p, first match wins:
  1. rst=1 or re_p=0 or raddr_p=0 -> 0.
  2. ex_write_i=1 and ex_addr_i==raddr_p -> ex_data_i.
  3. mem_write_i=1 and mem_addr_i==raddr_p -> mem_data_i.
  4. wb_write_i=1 and wb_addr_i==raddr_p -> wb_data_i (write-through bypass of the same-cycle write).
  5. otherwise regs[raddr_p].
- Stall:
  - stall_req_o = ex_write_i and ex_is_load_i and ex_addr_i!=0 and ((re1_i and raddr1_i==ex_addr_i) or (re2_i and raddr2_i==ex_addr_i)).
  - While stalled, port data is still driven by the priority above; ID discards it.
- Simultaneous hits:
  - Both ports on the same address return identical data.
  - EX/MEM/WB all targeting the same register -> EX wins.
- Writes to r0 from any stage never forward; r0 always reads 0.

Decomposition:
- Shared package (existing defines header):
  - types Bit_t, Reg_addr_t, Word_t.
  - constants ENABLE, DISABLE, REG_ZERO, ZERO_WORD.
  - new constant REG_NUM.
- One sub-module: regfile_fwd_mux, the per-port priority forwarding selector. It is instantiated twice, once per read port.
- Storage, counter and stall logic stay in regfile.

Test Plan:
- Reset:
  - Stimulus: write r5=0x1234 and count 1, then hold rst=1 one cycle.
  - Required response: read r5 -> 0, wr_count_o=0, stall_req_o=0, even with ex_is_load_i=1 and matching addresses.
- Write/read:
  - Stimulus: WB writes r3=0xDEADBEEF.
  - Required response: the same cycle re1 r3 returns 0xDEADBEEF (bypass); the next cycle, with no WB, returns it from the array; wr_count_o=1.
- r0:
  - Stimulus: WB/EX/MEM all write r0=0xFFFFFFFF.
  - Required response: read r0 on both ports -> 0; wr_count_o unchanged.
- Priority:
  - Stimulus: regs[7]=1; EX r7=0xA, MEM r7=0xB, WB r7=0xC in one cycle.
  - Required response: rdata1_o=rdata2_o=0xA.
  - Then drop EX -> 0xB; drop MEM -> 0xC; next cycle with no writes -> 0xC.
- Load-use:
  - Stimulus: ex_is_load_i=1, ex_addr r9, raddr2 r9, re2=1.
  - Required response: stall_req_o=1.
  - Same with re2=0 -> 0; ex_addr r0 -> 0.
- Counter wrap:
  - Stimulus: preload wr_count_o=0xFFFFFFFF via back-door force, then one valid write.
  - Required response: wr_count_o=0.
